// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the half-word-serial fetch unit.
// Contents: fetch FSM state encoding, instruction/half-word byte sizes and
// the RV32I base opcode map used by the fetch and decode stages.
package fetch_unit_pkg;

    localparam int INST_LEN_BYTES = 4;
    localparam int HALF_BYTES     = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_LO = 3'd1,
        S_FETCH_HI = 3'd2,
        S_ISSUE    = 3'd3,
        S_EXEC     = 3'd4
    } fetch_state_e;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_IMM    = 7'h13,
        OP_AUIPC  = 7'h17,
        OP_STORE  = 7'h23,
        OP_REG    = 7'h33,
        OP_LUI    = 7'h37,
        OP_BRANCH = 7'h63,
        OP_JALR   = 7'h67,
        OP_JAL    = 7'h6F,
        OP_SYSTEM = 7'h73
    } opcode_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: request/valid handshake carrying one 16-bit
// half-word per transfer.
//   req    : fetch request, held until rvalid
//   addr   : half-word byte address
//   rvalid : read data valid for the pending request (may be same cycle)
//   rdata  : instruction half-word
// master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            rvalid;
    logic [15:0]     rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit for the half-word-serial RV32I core. Fetches each instruction
// as two half-words (low first), holds it for the whole instruction and
// advances or redirects the PC when execute retires it.
// Ports:
//   clk, rst_n   : core clock, async active-low reset
//   imem         : instruction-memory port (fetch_unit_if.master)
//   exe_done     : execute retires current instruction (1-cycle pulse)
//   jmp_valid    : redirect taken, qualified by exe_done
//   jmp_target   : redirect target
//   inst, opcode, funct3, funct7, pc : held instruction, fields, its PC
//   inst_valid   : instruction valid (ISSUE, EXEC)
//   first_cycle  : flop-driven strobe, high exactly during ISSUE
//   illegal      : inst[1:0] != 2'b11 while valid
//   misalign     : 1-cycle pulse when a redirect target is not word aligned
//
// state      | meaning
// S_IDLE     | post-reset bubble, no request
// S_FETCH_LO | requesting low half at pc
// S_FETCH_HI | requesting high half at pc+2
// S_ISSUE    | first cycle of instruction, first_cycle high
// S_EXEC     | instruction held until exe_done
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    input  logic            exe_done,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    output logic [31:0]     inst,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic            inst_valid,
    output logic            first_cycle,
    output logic            illegal,
    output logic            misalign
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     inst_q;
    logic            req_q;
    logic            valid_q;
    logic            first_q;
    logic            misalign_q;

    // Request and address are registered so they stay stable across wait
    // states and drop the instant reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            inst_q     <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    state  <= S_FETCH_LO;
                    req_q  <= 1'b1;
                    addr_q <= pc_q;
                end
                S_FETCH_LO: begin
                    if (imem.rvalid) begin
                        inst_q[15:0] <= imem.rdata;
                        addr_q       <= pc_q + XLEN'(HALF_BYTES);
                        state        <= S_FETCH_HI;
                    end
                end
                S_FETCH_HI: begin
                    if (imem.rvalid) begin
                        inst_q[31:16] <= imem.rdata;
                        req_q         <= 1'b0;
                        valid_q       <= 1'b1;
                        first_q       <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    first_q <= 1'b0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (exe_done) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= S_FETCH_LO;
                        if (jmp_valid) begin
                            // Low bits are dropped; the core only supports word-aligned PCs.
                            pc_q       <= {jmp_target[XLEN-1:2], 2'b00};
                            addr_q     <= {jmp_target[XLEN-1:2], 2'b00};
                            misalign_q <= |jmp_target[1:0];
                        end else begin
                            pc_q   <= pc_q + XLEN'(INST_LEN_BYTES);
                            addr_q <= pc_q + XLEN'(INST_LEN_BYTES);
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req    = req_q;
    assign imem.addr   = addr_q;

    assign inst        = inst_q;
    assign opcode      = inst_q[6:0];
    assign funct3      = inst_q[14:12];
    assign funct7      = inst_q[31:25];
    assign pc          = pc_q;
    assign inst_valid  = valid_q;
    assign first_cycle = first_q;
    assign misalign    = misalign_q;
    // Illegal instructions are still issued; downstream decides what to do.
    assign illegal     = valid_q && (inst_q[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a configurable-latency memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exe_done = 1'b0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = '0;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic        inst_valid;
    logic        first_cycle;
    logic        illegal;
    logic        misalign;

    fetch_unit_if #(.XLEN(32)) imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .exe_done    (exe_done),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .inst        (inst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .first_cycle (first_cycle),
        .illegal     (illegal),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    // memory model: rvalid after 'delay' wait cycles; spur injects stray rvalid
    int          delay = 0;
    logic        spur = 1'b0;
    logic [15:0] lo_word = 16'h0093;
    logic [15:0] hi_word = 16'h0010;
    logic [3:0]  wait_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         wait_cnt <= '0;
        else if (!imem.req || imem.rvalid)  wait_cnt <= '0;
        else                                wait_cnt <= wait_cnt + 4'd1;
    end

    assign imem.rvalid = (imem.req && (int'(wait_cnt) >= delay)) || spur;
    assign imem.rdata  = spur ? 16'hFFFF : (imem.addr[1] ? hi_word : lo_word);

    // monitors, all sampled on the falling edge
    logic [31:0] addr_log[$];
    int          fc_cnt = 0;
    int          mis_cnt = 0;
    int          stab_err = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (first_cycle) fc_cnt <= fc_cnt + 1;
        if (misalign) mis_cnt <= mis_cnt + 1;
        if (imem.req && imem.rvalid) addr_log.push_back(imem.addr);
        if (!rst_n) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait && (!imem.req || imem.addr != prev_addr)) stab_err <= stab_err + 1;
            prev_wait <= imem.req && !imem.rvalid;
            prev_addr <= imem.addr;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance until first_cycle is seen; clears exe_done/jmp_valid after one edge
    task automatic run_to_issue(input int max, output int n, output int iv_early);
        n = 0;
        iv_early = 0;
        do begin
            @(negedge clk);
            n++;
            exe_done  = 1'b0;
            jmp_valid = 1'b0;
            if (inst_valid && !first_cycle) iv_early++;
        end while (!first_cycle && n < max);
        if (!first_cycle) chk_val("issue_timeout", 32'(first_cycle), 32'd1);
    endtask

    int n, iv, fc0, mis0;

    initial begin
        // ---- reset state
        repeat (2) @(negedge clk);
        chk_val("rst_req", 32'(imem.req), 32'd0);
        chk_val("rst_inst", inst, 32'h0);
        chk_val("rst_pc", pc, 32'h0);
        chk_val("rst_valid", {30'd0, inst_valid, first_cycle}, 32'd0);
        chk_val("rst_misc", {30'd0, illegal, misalign}, 32'd0);

        // ---- zero-wait fetch after reset release
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_val("lo_addr", imem.addr, 32'h0);
        chk_val("lo_req_fc", {30'd0, imem.req, first_cycle}, 32'b10);
        @(negedge clk);
        chk_val("hi_addr", imem.addr, 32'h2);
        chk_val("hi_fc", 32'(first_cycle), 32'd0);
        @(negedge clk);
        chk_val("issue_fc", 32'(first_cycle), 32'd1);
        chk_val("issue_inst", inst, 32'h0010_0093);
        chk_val("issue_opcode", 32'(opcode), 32'(OP_IMM));
        chk_val("issue_valid_ill", {30'd0, inst_valid, illegal}, 32'b10);
        exe_done = 1'b1;                 // must be ignored in ISSUE
        @(negedge clk);
        exe_done = 1'b0;
        chk_val("exec_fc_valid", {30'd0, first_cycle, inst_valid}, 32'b01);
        chk_val("exec_ignore_done_req", 32'(imem.req), 32'd0);
        chk_val("exec_ignore_done_pc", pc, 32'h0);
        spur = 1'b1;                     // stray rvalid in EXEC
        @(negedge clk);
        spur = 1'b0;
        chk_val("spur_inst", inst, 32'h0010_0093);
        chk_val("spur_req", 32'(imem.req), 32'd0);
        chk_val("fc_once_a", 32'(fc_cnt), 32'd1);

        // ---- 3-cycle memory latency
        delay = 3; lo_word = 16'h0113; hi_word = 16'h0020;
        addr_log.delete();
        fc0 = fc_cnt;
        exe_done = 1'b1;
        run_to_issue(40, n, iv);
        chk_val("slow_cycles", 32'(n), 32'd9);
        chk_val("slow_valid_early", 32'(iv), 32'd0);
        chk_val("slow_inst", inst, 32'h0020_0113);
        chk_val("slow_pc", pc, 32'h4);
        chk_val("slow_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h4);
        chk_val("slow_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'h6);
        @(negedge clk);
        chk_val("slow_fc_once", 32'(fc_cnt - fc0), 32'd1);
        chk_val("slow_stable", 32'(stab_err), 32'd0);

        // ---- redirect to top of memory, then sequential wrap
        delay = 0;
        addr_log.delete();
        mis0 = mis_cnt;
        exe_done = 1'b1; jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
        run_to_issue(20, n, iv);
        chk_val("top_cycles", 32'(n), 32'd3);
        chk_val("top_pc", pc, 32'hFFFF_FFFC);
        chk_val("top_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFE);
        chk_val("top_no_misalign", 32'(mis_cnt - mis0), 32'd0);
        @(negedge clk);
        addr_log.delete();
        exe_done = 1'b1;
        run_to_issue(20, n, iv);
        chk_val("wrap_pc", pc, 32'h0);
        chk_val("wrap_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk_val("wrap_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'h2);

        // ---- misaligned redirect
        @(negedge clk);
        addr_log.delete();
        mis0 = mis_cnt;
        exe_done = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h0000_0102;
        @(negedge clk);
        exe_done = 1'b0; jmp_valid = 1'b0;
        chk_val("mis_pulse", 32'(misalign), 32'd1);
        chk_val("mis_pc", pc, 32'h100);
        run_to_issue(20, n, iv);
        chk_val("mis_once", 32'(mis_cnt - mis0), 32'd1);
        chk_val("mis_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h100);
        chk_val("mis_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'h102);

        // ---- exe_done during fetch is ignored
        @(negedge clk);
        delay = 2;
        addr_log.delete();
        exe_done = 1'b1;
        @(negedge clk);
        exe_done = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h0000_0040;
        @(negedge clk);
        exe_done = 1'b0; jmp_valid = 1'b0;
        chk_val("fdone_pc", pc, 32'h104);
        chk_val("fdone_addr", imem.addr, 32'h104);
        chk_val("fdone_req", 32'(imem.req), 32'd1);
        run_to_issue(20, n, iv);
        chk_val("fdone_issue_pc", pc, 32'h104);
        chk_val("fdone_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'h106);

        // ---- async reset in FETCH_HI, then illegal instruction
        @(negedge clk);
        delay = 3;
        exe_done = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            exe_done = 1'b0;
            n++;
        end while (!(imem.req && imem.addr[1]) && n < 20);
        chk_val("reach_hi_addr", imem.addr, 32'h10A);
        #2 rst_n = 1'b0;
        #1;
        chk_val("async_req_drop", 32'(imem.req), 32'd0);
        chk_val("async_pc", pc, 32'h0);
        chk_val("async_valid", 32'(inst_valid), 32'd0);
        delay = 0; lo_word = 16'h0001; hi_word = 16'h0000;
        addr_log.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_to_issue(20, n, iv);
        chk_val("rst2_cycles", 32'(n), 32'd3);
        chk_val("rst2_valid_early", 32'(iv), 32'd0);
        chk_val("rst2_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk_val("ill_inst", inst, 32'h0000_0001);
        chk_val("ill_issue", {30'd0, illegal, inst_valid}, 32'b11);
        @(negedge clk);
        chk_val("ill_exec", {30'd0, illegal, inst_valid}, 32'b11);
        chk_val("final_stable", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
